sm_imem_loader: RTL



---
 rtl/sm_imem_loader.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sm_imem_loader.sv
// Instruction memory for the single-cycle schoolMIPS core with a byte-serial load port.
// The CPU reads words combinationally; a byte stream refills the array at run time while
// the CPU is held in reset. Bytes are assembled big-endian, four per word.
// Optional: define SM_IMEM_LOADER_CHECKSUM_EN to add the ld_sum byte-checksum output.
module sm_imem_loader #(
    parameter int unsigned SIZE   = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       imAddr,
    output logic [31:0]       imData,
    input  logic              ld_start,
    input  logic              ld_stop,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    output logic              ld_ready,
    output logic              ld_busy,
    output logic [ADDR_W:0]   ld_words,
    output logic              cpu_rst_n
`ifdef SM_IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [7:0]        ld_sum
`endif
);

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    localparam logic [ADDR_W:0] FullWords = (ADDR_W + 1)'(SIZE);

    state_e            state_q, state_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [23:0]       buf_q, buf_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              mem_we;
    logic [31:0]       mem_wdata;

    // Not reset: contents survive rst_n so a reset mid-load keeps earlier words.
    logic [31:0]       mem [SIZE];

`ifdef SM_IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    // Next-state, byte assembly and word-write strobe.
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        words_d    = words_q;
        buf_d      = buf_q;
        mem_we     = 1'b0;
        mem_wdata  = {buf_q, ld_data};
`ifdef SM_IMEM_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (ld_start) begin
                    state_d    = StLoad;
                    byte_idx_d = '0;
                    words_d    = '0;
`ifdef SM_IMEM_LOADER_CHECKSUM_EN
                    sum_d      = '0;
`endif
                end
            end
            StLoad: begin
                if (ld_start) begin
                    // Restart wins over any byte or stop in the same cycle.
                    byte_idx_d = '0;
                    words_d    = '0;
`ifdef SM_IMEM_LOADER_CHECKSUM_EN
                    sum_d      = '0;
`endif
                end else begin
                    if (ld_valid) begin
`ifdef SM_IMEM_LOADER_CHECKSUM_EN
                        sum_d = sum_q + ld_data;
`endif
                        if (byte_idx_q == 2'd3) begin
                            mem_we     = 1'b1;
                            words_d    = words_q + 1'b1;
                            byte_idx_d = '0;
                            if (words_d == FullWords) state_d = StDone;
                        end else begin
                            byte_idx_d = byte_idx_q + 1'b1;
                            buf_d      = {buf_q[15:0], ld_data};
                        end
                    end
                    // Byte is taken first, so a completing byte still lands in memory.
                    if (ld_stop) state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Release the CPU one edge after sitting in IDLE; hold it on the start edge.
        cpu_rst_n_d = (state_q == StIdle) && !ld_start;
    end

    // Loader state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            byte_idx_q  <= '0;
            words_q     <= '0;
            buf_q       <= '0;
            cpu_rst_n_q <= 1'b0;
`ifdef SM_IMEM_LOADER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            words_q     <= words_d;
            buf_q       <= buf_d;
            cpu_rst_n_q <= cpu_rst_n_d;
`ifdef SM_IMEM_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    // Memory write port; the word address is the low bits of the word count.
    always_ff @(posedge clk) begin
        if (mem_we) mem[words_q[ADDR_W-1:0]] <= mem_wdata;
    end

    // Combinational fetch; out-of-range addresses and loads return NOP.
    always_comb begin
        imData = 32'h0000_0000;
        if (state_q == StIdle && imAddr[31:ADDR_W] == '0) imData = mem[imAddr[ADDR_W-1:0]];
    end

    assign ld_ready  = (state_q == StLoad);
    assign ld_busy   = (state_q != StIdle);
    assign ld_words  = words_q;
    assign cpu_rst_n = cpu_rst_n_q;
`ifdef SM_IMEM_LOADER_CHECKSUM_EN
    assign ld_sum    = sum_q;
`endif

endmodule
